// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit detection, mid-bit sampling of
// DATA_BITS data bits (LSB first) and one stop bit. Emits a one-cycle
// data_valid strobe for good frames and a one-cycle frame_err strobe
// when the stop bit is sampled low.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 sync1;
    logic                 rxs;

    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic                 half_hit;
    logic                 full_hit;
    logic                 last_bit;

    logic [DATA_BITS-1:0] data_out_next;
    logic                 data_valid_next;
    logic                 frame_err_next;
    logic                 busy_next;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    // Sample-point qualifiers, only meaningful on clocks carrying a tick.
    always_comb begin
        half_hit = tick && (tick_cnt == HALF_LAST);
        full_hit = tick && (tick_cnt == FULL_LAST);
        last_bit = (bit_cnt == BIT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (half_hit) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end else begin
                    state_next = START;
                end
            end
            DATA: begin
                if (full_hit && last_bit) begin
                    state_next = STOP;
                end else begin
                    state_next = DATA;
                end
            end
            STOP: begin
                if (full_hit) begin
                    state_next = IDLE;
                end else begin
                    state_next = STOP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        data_out_next   = data_out;
        case (state)
            STOP: begin
                if (full_hit) begin
                    if (rxs) begin
                        data_valid_next = 1'b1;
                        data_out_next   = shift_reg;
                    end else begin
                        frame_err_next  = 1'b1;
                    end
                end else begin
                    data_valid_next = 1'b0;
                    frame_err_next  = 1'b0;
                end
            end
            default: begin
                data_valid_next = 1'b0;
                frame_err_next  = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // Registered outputs so downstream logic sees glitch-free strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= {DATA_BITS{1'b0}};
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_out   <= data_out_next;
            data_valid <= data_valid_next;
            frame_err  <= frame_err_next;
            busy       <= busy_next;
        end
    end

    // Oversample counter, bit counter and shift register; advance on ticks only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= TW'(0);
            bit_cnt   <= BW'(0);
            shift_reg <= {DATA_BITS{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= TW'(0);
                    bit_cnt  <= BW'(0);
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= TW'(0);
                            bit_cnt  <= BW'(0);
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt  <= TW'(0);
                            // Right shift with new bit at the MSB rebuilds LSB-first data.
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            if (!last_bit) begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= TW'(0);
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    tick_cnt <= TW'(0);
                    bit_cnt  <= BW'(0);
                end
            endcase
        end
    end

endmodule
